// File: rtl/ps2_pkg.sv
// Shared types, scancode constants and small helpers for the PS/2 keyboard front end.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [7:0] KEY_ARW_RIGHT = 8'h74;
  localparam logic [7:0] KEY_ARW_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_ARW_UP    = 8'h75;
  localparam logic [7:0] KEY_ARW_DOWN  = 8'h72;
  localparam logic [7:0] KEY_W_RIGHT   = 8'h23;
  localparam logic [7:0] KEY_W_LEFT    = 8'h1C;
  localparam logic [7:0] KEY_W_UP      = 8'h1D;
  localparam logic [7:0] KEY_W_DOWN    = 8'h1B;

  localparam int EVT_W       = 10;
  localparam int EVT_EXT_BIT = 9;
  localparam int EVT_BRK_BIT = 8;

  // Direction vectors are packed {right, left, up, down}.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  function automatic logic [3:0] arrow_dir(input logic [7:0] code);
    case (code)
      KEY_ARW_RIGHT: return 4'b1000;
      KEY_ARW_LEFT:  return 4'b0100;
      KEY_ARW_UP:    return 4'b0010;
      KEY_ARW_DOWN:  return 4'b0001;
      default:       return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] wasd_dir(input logic [7:0] code);
    case (code)
      KEY_W_RIGHT: return 4'b1000;
      KEY_W_LEFT:  return 4'b0100;
      KEY_W_UP:    return 4'b0010;
      KEY_W_DOWN:  return 4'b0001;
      default:     return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 line conditioning (sync + glitch filter) and 11-bit frame receiver with timeout.
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_err
);
  import ps2_pkg::*;

  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]       clk_sync_r, data_sync_r;
  logic             clk_filt_r, data_filt_r;
  logic [FLT_W-1:0] clk_cnt_r, data_cnt_r;
  logic             fall_r;
  frame_state_t     state_r;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       shift_r;
  logic             par_r;
  logic [TMO_W-1:0] tmo_r;
  logic [7:0]       rx_byte_r;
  logic             rx_strobe_r, rx_err_r;

  // Synchronise both lines, filter them and flag filtered ps2clk falling edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
      clk_filt_r  <= 1'b1;
      data_filt_r <= 1'b1;
      clk_cnt_r   <= {FLT_W{1'b0}};
      data_cnt_r  <= {FLT_W{1'b0}};
      fall_r      <= 1'b0;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2clk};
      data_sync_r <= {data_sync_r[0], ps2data};
      fall_r      <= clk_filt_r & ~clk_sync_r[1] & (clk_cnt_r == FLT_W'(FILTER_LEN - 1));
      if (clk_sync_r[1] != clk_filt_r) begin
        if (clk_cnt_r == FLT_W'(FILTER_LEN - 1)) begin
          clk_filt_r <= clk_sync_r[1];
          clk_cnt_r  <= {FLT_W{1'b0}};
        end else begin
          clk_cnt_r <= clk_cnt_r + FLT_W'(1);
        end
      end else begin
        clk_cnt_r <= {FLT_W{1'b0}};
      end
      if (data_sync_r[1] != data_filt_r) begin
        if (data_cnt_r == FLT_W'(FILTER_LEN - 1)) begin
          data_filt_r <= data_sync_r[1];
          data_cnt_r  <= {FLT_W{1'b0}};
        end else begin
          data_cnt_r <= data_cnt_r + FLT_W'(1);
        end
      end else begin
        data_cnt_r <= {FLT_W{1'b0}};
      end
    end
  end

  // Frame FSM; a stalled frame is abandoned after TIMEOUT_CYCLES strobe-free cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      par_r       <= 1'b0;
      tmo_r       <= {TMO_W{1'b0}};
      rx_byte_r   <= 8'h00;
      rx_strobe_r <= 1'b0;
      rx_err_r    <= 1'b0;
    end else begin
      rx_strobe_r <= 1'b0;
      rx_err_r    <= 1'b0;
      if (state_r == IDLE || fall_r) begin
        tmo_r <= {TMO_W{1'b0}};
      end else begin
        tmo_r <= tmo_r + TMO_W'(1);
      end
      if (state_r != IDLE && !fall_r && tmo_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        state_r  <= IDLE;
        rx_err_r <= 1'b1;
      end else if (fall_r) begin
        case (state_r)
          IDLE: begin
            if (!data_filt_r) begin
              state_r   <= DATA;
              bit_cnt_r <= 3'd0;
            end
          end
          DATA: begin
            shift_r <= {data_filt_r, shift_r[7:1]};
            if (bit_cnt_r == 3'd7) begin
              state_r <= PARITY;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
          PARITY: begin
            par_r   <= data_filt_r;
            state_r <= STOP;
          end
          STOP: begin
            state_r <= IDLE;
            if (data_filt_r && odd_parity_ok(shift_r, par_r)) begin
              rx_byte_r   <= shift_r;
              rx_strobe_r <= 1'b1;
            end else begin
              rx_err_r <= 1'b1;
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  assign rx_byte   = rx_byte_r;
  assign rx_strobe = rx_strobe_r;
  assign rx_err    = rx_err_r;

endmodule

// File: rtl/ps2_kbd_events.sv
// PS/2 keyboard front end: prefix decode, direction outputs and event FIFO.
module ps2_kbd_events #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int DIR_PULSE      = 0,
  parameter int WASD_EN        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [9:0] code_data,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       right,
  output logic       left,
  output logic       up,
  output logic       down,
  output logic       frame_err,
  output logic       fifo_ovf,
  input  logic       err_clr
);
  import ps2_pkg::*;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       rx_byte_s;
  logic             rx_strobe_s, rx_err_s;
  logic             ext_r, brk_r;
  logic             evt_s, push_ok_s, pop_s, full_s, drop_s;
  logic [EVT_W-1:0] evt_data_s;
  logic [EVT_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [3:0]       arrow_hit_s, wasd_hit_s;
  logic [3:0]       arrow_nx_s, wasd_nx_s, pulse_nx_s;
  logic [3:0]       arrow_r, wasd_r, dir_r;
  logic             frame_err_r, fifo_ovf_r;

  ps2_rx_frame #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .ps2clk   (ps2clk),
    .ps2data  (ps2data),
    .rx_byte  (rx_byte_s),
    .rx_strobe(rx_strobe_s),
    .rx_err   (rx_err_s)
  );

  assign evt_s      = rx_strobe_s && (rx_byte_s != PS2_EXT) && (rx_byte_s != PS2_BRK);
  assign evt_data_s = {ext_r, brk_r, rx_byte_s};
  assign full_s     = (count_r == CNT_W'(FIFO_DEPTH));
  assign pop_s      = code_valid && code_ready;
  assign push_ok_s  = evt_s && (!full_s || pop_s);
  assign drop_s     = evt_s && full_s && !pop_s;

  // Prefix flags: a line error also forgets any pending E0/F0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_r <= 1'b0;
      brk_r <= 1'b0;
    end else if (rx_err_s) begin
      ext_r <= 1'b0;
      brk_r <= 1'b0;
    end else if (rx_strobe_s) begin
      if (rx_byte_s == PS2_EXT) begin
        ext_r <= 1'b1;
      end else if (rx_byte_s == PS2_BRK) begin
        brk_r <= 1'b1;
      end else begin
        ext_r <= 1'b0;
        brk_r <= 1'b0;
      end
    end
  end

  // Event FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {EVT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= evt_data_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign code_valid = (count_r != {CNT_W{1'b0}});
  assign code_data  = mem_r[rd_ptr_r];

  // Next direction state: arrow and WASD sources kept apart so releasing one keeps the other.
  always_comb begin
    arrow_hit_s = ext_r ? arrow_dir(rx_byte_s) : 4'b0000;
    wasd_hit_s  = (!ext_r && WASD_EN != 0) ? wasd_dir(rx_byte_s) : 4'b0000;
    arrow_nx_s  = arrow_r;
    wasd_nx_s   = wasd_r;
    pulse_nx_s  = 4'b0000;
    if (evt_s && brk_r) begin
      arrow_nx_s = arrow_r & ~arrow_hit_s;
      wasd_nx_s  = wasd_r & ~wasd_hit_s;
    end else if (evt_s) begin
      arrow_nx_s = arrow_r | arrow_hit_s;
      wasd_nx_s  = wasd_r | wasd_hit_s;
      pulse_nx_s = arrow_hit_s | wasd_hit_s;
    end else begin
      pulse_nx_s = 4'b0000;
    end
  end

  // Direction registers and sticky error flags (set beats clear).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arrow_r     <= 4'b0000;
      wasd_r      <= 4'b0000;
      dir_r       <= 4'b0000;
      frame_err_r <= 1'b0;
      fifo_ovf_r  <= 1'b0;
    end else begin
      arrow_r     <= arrow_nx_s;
      wasd_r      <= wasd_nx_s;
      dir_r       <= (DIR_PULSE != 0) ? pulse_nx_s : (arrow_nx_s | wasd_nx_s);
      frame_err_r <= rx_err_s ? 1'b1 : (err_clr ? 1'b0 : frame_err_r);
      fifo_ovf_r  <= drop_s   ? 1'b1 : (err_clr ? 1'b0 : fifo_ovf_r);
    end
  end

  assign right     = dir_r[3];
  assign left      = dir_r[2];
  assign up        = dir_r[1];
  assign down      = dir_r[0];
  assign frame_err = frame_err_r;
  assign fifo_ovf  = fifo_ovf_r;

endmodule

// File: tb/tb_ps2_kbd_events.sv
// Directed bench: one level-mode and one pulse-mode instance share the PS/2 lines.
module tb_ps2_kbd_events;

  localparam int DEPTH = 4;
  localparam int TMO   = 300;

  logic clk = 1'b0;
  logic rst, ps2clk, ps2data, err_clr, rdy_l, rdy_p;
  logic [9:0] data_l, data_p;
  logic valid_l, valid_p;
  logic right_l, left_l, up_l, down_l, ferr_l, ovf_l;
  logic right_p, left_p, up_p, down_p, ferr_p, ovf_p;

  int n_tests = 0;
  int n_fail  = 0;
  int hi_cnt  = 0;
  int rise_cnt = 0;
  logic prev_p = 1'b0;

  always #5 clk = ~clk;

  ps2_kbd_events #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(2), .TIMEOUT_CYCLES(TMO),
                   .DIR_PULSE(0), .WASD_EN(1)) u_lvl (
    .clk(clk), .rst(rst), .ps2clk(ps2clk), .ps2data(ps2data),
    .code_data(data_l), .code_valid(valid_l), .code_ready(rdy_l),
    .right(right_l), .left(left_l), .up(up_l), .down(down_l),
    .frame_err(ferr_l), .fifo_ovf(ovf_l), .err_clr(err_clr));

  ps2_kbd_events #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(2), .TIMEOUT_CYCLES(TMO),
                   .DIR_PULSE(1), .WASD_EN(1)) u_pls (
    .clk(clk), .rst(rst), .ps2clk(ps2clk), .ps2data(ps2data),
    .code_data(data_p), .code_valid(valid_p), .code_ready(rdy_p),
    .right(right_p), .left(left_p), .up(up_p), .down(down_p),
    .frame_err(ferr_p), .fifo_ovf(ovf_p), .err_clr(err_clr));

  // Measure pulse-mode right output: total high cycles and rising edges.
  always @(negedge clk) begin
    prev_p <= right_p;
    if (right_p) hi_cnt <= hi_cnt + 1;
    if (right_p && !prev_p) rise_cnt <= rise_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2data = b;
    cycles(4);
    ps2clk = 1'b0;
    cycles(8);
    ps2clk = 1'b1;
    cycles(4);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ bad_par);
    send_bit(1'b1);
    cycles(20);
  endtask

  task automatic pop_l();
    rdy_l = 1'b1;
    cycles(1);
    rdy_l = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] ovf_codes [5];
    int hi0, rise0;
    ovf_codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};

    rst = 1'b0; ps2clk = 1'b1; ps2data = 1'b1; err_clr = 1'b0;
    rdy_l = 1'b0; rdy_p = 1'b1;
    cycles(3);
    check("reset_outs_l", {data_l, valid_l, right_l, left_l, up_l, down_l, ferr_l, ovf_l}, 32'd0);
    check("reset_outs_p", {data_p, valid_p, right_p, left_p, up_p, down_p, ferr_p, ovf_p}, 32'd0);
    rst = 1'b1;
    cycles(20);

    // Extended make, then a bad-parity frame, then the extended break.
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("make_valid", valid_l, 1);
    check("make_data", data_l, 10'h275);
    check("make_up", up_l, 1);
    pop_l();
    check("make_popped", valid_l, 0);

    send_frame(8'h1D, 1'b1);
    check("par_err", ferr_l, 1);
    check("par_no_evt", valid_l, 0);
    check("par_up_kept", up_l, 1);
    pulse_clr();
    check("err_clr", ferr_l, 0);

    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("brk_data", data_l, 10'h375);
    check("brk_up", up_l, 0);
    pop_l();

    // Frame abandoned after 4 data bits.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    cycles(TMO + 20);
    check("tmo_err", ferr_l, 1);
    check("tmo_no_evt", valid_l, 0);
    send_frame(8'h1C, 1'b0);
    check("tmo_next_data", data_l, 10'h01C);
    check("tmo_next_left", left_l, 1);
    pop_l();
    pulse_clr();
    check("tmo_clr", ferr_l, 0);

    // Overflow: DEPTH+1 makes with the consumer stalled.
    for (int i = 0; i < 5; i++) send_frame(ovf_codes[i], 1'b0);
    check("ovf_flag", ovf_l, 1);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain_valid%0d", i), valid_l, 1);
      check($sformatf("drain_data%0d", i), data_l, {2'b00, ovf_codes[i]});
      pop_l();
    end
    check("drain_empty", valid_l, 0);

    // Typematic arrow makes and a break: pulse mode counts, level mode holds.
    hi0 = hi_cnt; rise0 = rise_cnt;
    for (int i = 0; i < 3; i++) begin
      send_frame(8'hE0, 1'b0);
      send_frame(8'h74, 1'b0);
    end
    check("lvl_right_held", right_l, 1);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h74, 1'b0);
    check("lvl_right_rel", right_l, 0);
    check("pls_rises", rise_cnt - rise0, 3);
    check("pls_hi_cycles", hi_cnt - hi0, 3);
    check("pls_rest", right_p, 0);

    // Asynchronous reset in the middle of a frame.
    check("pre_rst_left", left_l, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #2 rst = 1'b0;
    #1;
    check("rst_outs_l", {valid_l, right_l, left_l, up_l, down_l, ferr_l, ovf_l}, 32'd0);
    check("rst_outs_p", {valid_p, right_p, left_p, up_p, down_p, ferr_p, ovf_p}, 32'd0);
    ps2data = 1'b1;
    cycles(3);
    rst = 1'b1;
    cycles(20);
    send_frame(8'h1D, 1'b0);
    check("post_rst_data", data_l, 10'h01D);
    check("post_rst_up", up_l, 1);
    check("post_rst_err", ferr_l, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_events.md
Name: ps2_kbd_events

Overview:
- Next-generation PS/2 keyboard front end for the snake game.
- Receives raw PS/2 frames and checks them:
  - parity and stop bit checked;
  - inter-bit timeout detected;
  - E0/F0 prefixes decoded into make/break events;
  - events buffered in a parametrised FIFO with a valid/ready interface.
- Drives four direction outputs in either held-level or one-shot mode, with optional WASD mapping alongside the arrow keys.
- Sits between the PS/2 pins and the game control logic.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries (power of two, at least 2).
- FILTER_LEN, 8, consecutive equal synchronised samples needed before ps2clk/ps2data are considered changed.
- TIMEOUT_CYCLES, 100000, clk cycles allowed without a ps2clk falling edge mid-frame before the frame is aborted.
- DIR_PULSE, 0, direction output mode:
  - 0: level (key held);
  - 1: single-cycle pulse per make code.
- WASD_EN, 1, 1 = W/A/S/D also drive up/left/down/right.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ps2clk  in  1  raw PS/2 clock.
- ps2data  in  1  raw PS/2 data.
- code_data  out  10  FIFO head: {ext, brk, code[7:0]}.
- code_valid  out  1  FIFO non-empty.
- code_ready  in  1  consumer accepts head when code_valid=1.
- right, left, up, down  out  1 each  direction outputs.
- frame_err  out  1  sticky: parity, stop or timeout error.
- fifo_ovf  out  1  sticky: event dropped because FIFO full.
- err_clr  in  1  clears both sticky flags.

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs 0, FIFO empty, prefix flags clear, receiver in IDLE;
  - a reset mid-frame discards the partial frame.
- Input conditioning:
  - 2-FF synchroniser on each input, then the FILTER_LEN filter;
  - filtered ps2clk 1→0 transition = one sample strobe; data is sampled on that strobe.
- Frame FSM:
  - IDLE: strobe with data=0 → DATA, bit count 0; strobe with data=1 → stays IDLE, no error.
  - DATA: 8 strobes, LSB first, then → PARITY.
  - PARITY: stores the bit → STOP.
  - STOP: → IDLE. Byte valid only if stop=1 and the 9 bits (data+parity) have odd parity. Otherwise the byte is discarded, frame_err is set and both prefix flags clear.
- Timeout: in any non-IDLE state, TIMEOUT_CYCLES clk cycles with no strobe → IDLE, frame_err set, prefix flags cleared.
- Prefix decode of each valid byte:
  - 0xE0 sets ext; 0xF0 sets brk; neither produces an event.
  - Any other byte forms the event {ext, brk, byte}, then ext and brk clear.
  - E0 F0 xx gives ext=1, brk=1.
  - All other codes (including 0xAA, 0xE1) are plain events.
- Latency:
  - STOP strobe at cycle N → event written into FIFO at N+1 → code_valid high at N+2 if FIFO was empty.
  - Direction outputs update at N+1.
- Direction mapping:
  - Arrow keys (ext=1): 0x74 right, 0x6B left, 0x75 up, 0x72 down.
  - If WASD_EN (ext=0): 0x23 right, 0x1C left, 0x1D up, 0x1B down.
  - Level mode: make (brk=0) sets the output, break clears it. Arrow and WASD sources are ORed per direction, each tracked separately.
  - Pulse mode: each make event, including typematic repeats, gives exactly one 1-cycle pulse; breaks ignored.
  - Direction update is independent of FIFO fullness.
- FIFO:
  - First-word fall-through; code_data is valid whenever code_valid=1 and holds stable until popped.
  - Pop when code_valid && code_ready.
  - Push accepted if not full, or if full with a pop in the same cycle.
  - Push while full with no pop: event dropped, fifo_ovf set, FIFO contents unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- Sticky flags: err_clr clears both flags next cycle; if an error event coincides with err_clr, set wins.

Decomposition:
- Shared package ps2_pkg:
  - frame state enum (IDLE, DATA, PARITY, STOP);
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0;
  - arrow/WASD scancode constants;
  - event width (10) and field positions.
- Sub-module ps2_rx_frame: synchroniser, filter, frame FSM and timeout. Outputs rx_byte[7:0], rx_strobe and rx_err. Prefix decode, direction logic and FIFO stay in the top.

Test Plan:
- Send frames E0, 75 (valid parity) → code_data=10'h275, code_valid=1; up=1 in level mode. Then E0 F0 75 → event 10'h375; up=0.
- Send 1D with corrupted parity bit → no event, frame_err=1, up unchanged. Then pulse err_clr → frame_err=0.
- Stop ps2clk after 4 data bits for TIMEOUT_CYCLES+1 cycles → frame_err=1, receiver back in IDLE. A following clean frame 0x1C gives event 10'h01C and left=1 (WASD_EN=1).
- Hold code_ready=0 and send FIFO_DEPTH+1 make codes → first FIFO_DEPTH events retained in order, fifo_ovf=1. Then raise code_ready → events drain in order, code_valid=0 after the last.
- DIR_PULSE=1: send 0x74 three times as E0-prefixed makes → right pulses exactly 3 single-cycle highs; the E0 F0 74 break produces no pulse.
- Assert rst=0 midway through a frame → all outputs 0 immediately. After release, the next complete frame decodes correctly.
